// File: rtl/my_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : my_fetch_pkg                                                    |
// | Purpose  : Shared types and default widths for the my_fetch fetch stage.   |
// |            fetch_state_t : fetch FSM states (IDLE / WAIT / DROP)           |
// |            fetch_entry_t : instruction buffer entry {addr, data}           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package my_fetch_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 16;

    // IDLE: nothing outstanding; WAIT: one read outstanding;
    // DROP: one read outstanding whose response must be thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/my_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : my_fetch_if                                                     |
// | Purpose  : ROM read bus plus decode-side valid/ready handshake of the      |
// |            fetch stage.                                                    |
// |            master : the fetch stage (drives rom_req/rom_addr, instr_*)     |
// |            slave  : ROM + decode side (drives rom_valid/rom_data, ready)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface my_fetch_if
    import my_fetch_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_valid;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;

    modport master (
        output rom_req, rom_addr, instr_valid, instr, instr_addr,
        input  rom_valid, rom_data, instr_ready
    );

    modport slave (
        input  rom_req, rom_addr, instr_valid, instr, instr_addr,
        output rom_valid, rom_data, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/my_fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : my_fetch_fifo                                                   |
// | Purpose  : DEPTH-entry synchronous FIFO of fetch entries.                  |
// | Ports    : clk, reset_n (async active-low)                                 |
// |            push/push_data : write one entry                                |
// |            pop            : advance the head                               |
// |            clear          : empty the FIFO (beats push and pop)            |
// |            head           : oldest entry, count : occupancy                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module my_fetch_fifo
    import my_fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = fetch_entry_t
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 push,
    input  wire ENTRY_T               push_data,
    input  wire logic                 pop,
    input  wire logic                 clear,
    output ENTRY_T                    head,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    ENTRY_T               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    // Overflow/underflow guards; the owner never relies on them.
    assign w_do_push = push && (r_count != c_FULL);
    assign w_do_pop  = pop  && (r_count != '0);

    // Pointers are log2(DEPTH) bits, so the +1 wraps modulo DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/my_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : my_fetch                                                        |
// | Purpose  : Instruction fetch stage. Issues one ROM read at a time from the |
// |            current PC, pulses pc_inc on issue, buffers returned words and  |
// |            hands them to decode over valid/ready. flush (PC load) empties  |
// |            the buffer and discards any in-flight response.                |
// | Ports    : clk, reset_n (async active-low)                                 |
// |            pc_addr in, pc_inc out, flush in                                |
// |            bus (my_fetch_if.master): rom_req/rom_addr/rom_valid/rom_data,  |
// |                 instr_valid/instr_ready/instr/instr_addr                   |
// | Config   : MY_FETCH_BYPASS_EN - forward a ROM response straight to decode |
// |            when the buffer is empty (no buffer latency).                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module my_fetch
    import my_fetch_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = 2
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic [ADDR_W-1:0] pc_addr,
    output logic                   pc_inc,
    input  wire logic              flush,
    my_fetch_if.master             bus
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    fetch_state_t          r_state;
    logic [ADDR_W-1:0]     r_req_addr;
    logic [c_CNT_W-1:0]    w_count;
    entry_t                w_head;
    entry_t                w_push_data;
    logic                  w_issue;
    logic                  w_rsp_live;
    logic                  w_buf_valid;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;

    // Issue is decoded from registered state and count only; flush wins.
    // reset_n gating keeps rom_req/pc_inc low while reset is held.
    assign w_issue = reset_n && (r_state == IDLE) && !flush && (w_count < c_DEPTH_CNT);

    assign pc_inc       = w_issue;
    assign bus.rom_req  = w_issue;
    assign bus.rom_addr = w_issue ? pc_addr : '0;

    // A response is only useful in WAIT and when no jump is happening.
    assign w_rsp_live  = (r_state == WAIT) && bus.rom_valid && !flush;
    assign w_buf_valid = (w_count != '0);

`ifdef MY_FETCH_BYPASS_EN
    assign w_bypass = w_rsp_live && !w_buf_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that decode takes this cycle is never written.
    assign w_push = w_rsp_live && !(w_bypass && bus.instr_ready);
    assign w_pop  = w_buf_valid && bus.instr_ready;

    assign w_push_data.addr = r_req_addr;
    assign w_push_data.data = bus.rom_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_req_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state    <= WAIT;
                        r_req_addr <= pc_addr;
                    end
                end
                WAIT: begin
                    // A response in the flush cycle still closes the read.
                    if (bus.rom_valid) begin
                        r_state <= IDLE;
                    end else if (flush) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (bus.rom_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    my_fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .clear     (flush),
        .head      (w_head),
        .count     (w_count)
    );

    // Buffer head has priority; bypass only happens when the buffer is empty.
    always_comb begin
        bus.instr_valid = w_buf_valid || w_bypass;
        bus.instr       = '0;
        bus.instr_addr  = '0;
        if (w_buf_valid) begin
            bus.instr      = w_head.data;
            bus.instr_addr = w_head.addr;
        end else if (w_bypass) begin
            bus.instr      = bus.rom_data;
            bus.instr_addr = r_req_addr;
        end
    end

endmodule
`default_nettype wire
